// File: rtl/lvds_tx_framer.sv
// Frames parallel words into start/data/parity/stop serial bits and drives a
// TLVDS_TBUF data input plus its active-low output enable.
module lvds_tx_framer #(
  parameter int CLKS_PER_BIT  = 27,
  parameter int DATA_BITS     = 8,
  parameter int GUARD_BITS    = 1,
  parameter int PARITY        = 0,
  parameter int IDLE_TRISTATE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tbuf_i,
  output logic                 tbuf_oen,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, GUARD, START, DATA, PAR, STOP} state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 rst_q;
  logic                 bit_last;
  logic                 xfer;
  logic                 ti_nx;

  assign bit_last = (bit_cnt == CW'(CLKS_PER_BIT - 1));
  // rst_q keeps the handshake closed for the first cycle after reset release
  assign tx_ready = enable & ~rst & ~rst_q &
                    ((state == IDLE) | ((state == STOP) & bit_last));
  assign xfer     = tx_valid & tx_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (xfer) state_nx = (GUARD_BITS != 0) ? GUARD : START;
      GUARD: if (bit_last && bit_idx == IW'(GUARD_BITS - 1)) state_nx = START;
      START: if (bit_last) state_nx = DATA;
      DATA:  if (bit_last && bit_idx == IW'(DATA_BITS - 1))
               state_nx = (PARITY != 0) ? PAR : STOP;
      PAR:   if (bit_last) state_nx = STOP;
      STOP:  if (bit_last) state_nx = xfer ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next serial bit; inside DATA the shift happens on the same edge, so peek shreg[1]
  always_comb begin
    ti_nx = 1'b1;
    case (state_nx)
      START: ti_nx = 1'b0;
      DATA:  ti_nx = (state == DATA && bit_last) ? shreg[1] : shreg[0];
      PAR:   ti_nx = par_bit;
      default: ti_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      rst_q    <= 1'b1;
      tbuf_i   <= 1'b1;
      tbuf_oen <= 1'b1;
      busy     <= 1'b0;
    end else begin
      rst_q   <= 1'b0;
      state   <= state_nx;
      bit_cnt <= (state == IDLE || bit_last) ? '0 : bit_cnt + 1'b1;
      if (state_nx != state)
        bit_idx <= '0;
      else if (bit_last && (state == GUARD || state == DATA))
        bit_idx <= bit_idx + 1'b1;
      if (xfer) begin
        shreg   <= tx_data;
        par_bit <= (^tx_data) ^ (PARITY == 2);
      end else if (state == DATA && bit_last) begin
        shreg <= shreg >> 1;
      end
      tbuf_i   <= ti_nx;
      tbuf_oen <= (state_nx == IDLE) ? (IDLE_TRISTATE != 0) : 1'b0;
      busy     <= (state_nx != IDLE);
    end
  end
endmodule

// File: tb/tb_lvds_tx_framer.sv
// Directed bench: four framer configs share stimulus; each check targets one instance.
module tb_lvds_tx_framer;
  logic       clk, rst, enable, tx_valid;
  logic [7:0] tx_data;
  logic [3:0] rdy, ti, oen, bsy;
  int total = 0, bad = 0;

  logic [31:0] fr [4];
  int          len [4];
  int          ol [4];
  int          kk;

  // 0: base, 1: even parity, 2: odd parity, 3: driven idle
  lvds_tx_framer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .GUARD_BITS(1), .PARITY(0), .IDLE_TRISTATE(1)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy[0]), .tbuf_i(ti[0]), .tbuf_oen(oen[0]), .busy(bsy[0]));
  lvds_tx_framer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .GUARD_BITS(1), .PARITY(1), .IDLE_TRISTATE(1)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy[1]), .tbuf_i(ti[1]), .tbuf_oen(oen[1]), .busy(bsy[1]));
  lvds_tx_framer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .GUARD_BITS(1), .PARITY(2), .IDLE_TRISTATE(1)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy[2]), .tbuf_i(ti[2]), .tbuf_oen(oen[2]), .busy(bsy[2]));
  lvds_tx_framer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .GUARD_BITS(1), .PARITY(0), .IDLE_TRISTATE(0)) u3 (
    .clk(clk), .rst(rst), .enable(enable), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy[3]), .tbuf_i(ti[3]), .tbuf_oen(oen[3]), .busy(bsy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Runs until every instance is idle; samples each bit mid-bit-time.
  // dv: cycle whose edge carries a chained transfer; de: enable drop; rs: reset pulse
  task automatic capture(input int dv, input int de, input int rs);
    int k;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      fr[i] = '0; len[i] = 0; ol[i] = 0;
    end
    while (bsy != 4'b0 && k < 400) begin
      if (k == dv) chk("b2b_ready_last_stop", {31'b0, rdy[0]}, 1);
      if (k == dv + 1) tx_valid = 1'b0;
      if (k == de) enable = 1'b0;
      if (k == rs) rst = 1'b1;
      if (de >= 0 && k == 43) chk("en_drop_ready_low", {31'b0, rdy[0]}, 0);
      for (int i = 0; i < 4; i++) begin
        if (bsy[i]) begin
          if (k % 4 == 1 && k < 128) fr[i][k/4] = ti[i];
          len[i]++;
          if (!oen[i]) ol[i]++;
        end
      end
      step();
      k++;
    end
    chk("capture_timeout", {31'b0, k < 400}, 1);
    kk = k;
  endtask

  initial begin
    int glitch;
    rst = 1'b1; enable = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;

    // reset held with valid/enable high
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_oen", {31'b0, oen[0]}, 1);
      chk("rst_ti", {31'b0, ti[0]}, 1);
      chk("rst_busy", {31'b0, bsy[0]}, 0);
      chk("rst_ready", {31'b0, rdy[0]}, 0);
    end
    rst = 1'b0;
    #1;
    chk("rel1_ready", {31'b0, rdy[0]}, 0);
    chk("rel1_oen_it0", {31'b0, oen[3]}, 1);
    step();
    chk("rel2_ready", {31'b0, rdy[0]}, 1);
    chk("rel2_oen", {31'b0, oen[0]}, 1);
    chk("rel2_oen_it0", {31'b0, oen[3]}, 0);

    // single word 0xA5
    step();
    tx_valid = 1'b0;
    chk("a5_oen_low", {31'b0, oen[0]}, 0);
    chk("a5_busy", {31'b0, bsy[0]}, 1);
    capture(-1, -1, -1);
    chk("a5_frame", fr[0], {21'b0, 1'b1, 8'hA5, 1'b0, 1'b1});
    chk("a5_len", len[0], 44);
    chk("a5_oen_len", ol[0], 44);
    chk("a5_oen_end", {31'b0, oen[0]}, 1);
    chk("it0_idle_oen", {31'b0, oen[3]}, 0);
    chk("it0_idle_ti", {31'b0, ti[3]}, 1);

    // parity on 0x07
    tx_data = 8'h07; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    capture(-1, -1, -1);
    chk("even_frame", fr[1], {20'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1});
    chk("even_len", len[1], 48);
    chk("odd_frame", fr[2], {20'b0, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1});
    chk("odd_len", len[2], 48);
    chk("nopar_len", len[0], 44);

    // back-to-back 0x00 then 0xFF, second word offered mid-frame
    tx_data = 8'h00; tx_valid = 1'b1;
    step();
    tx_data = 8'hFF;
    capture(43, -1, -1);
    chk("b2b_frame", fr[0], {11'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1});
    chk("b2b_len", len[0], 84);
    chk("b2b_oen_len", ol[0], 84);
    chk("b2b_it0_len", len[3], 84);

    // enable dropped during data bit 3 of 0x3C, valid stays high
    tx_data = 8'h3C; tx_valid = 1'b1;
    step();
    capture(-1, 21, -1);
    chk("en_frame", fr[0], {21'b0, 1'b1, 8'h3C, 1'b0, 1'b1});
    chk("en_len", len[0], 44);
    chk("en_ready_after", {31'b0, rdy[0]}, 0);
    repeat (5) step();
    chk("en_no_second", {31'b0, bsy[0]}, 0);
    chk("en_oen_idle", {31'b0, oen[0]}, 1);
    tx_valid = 1'b0; enable = 1'b1;
    step();

    // reset pulse during data bit 5
    tx_data = 8'h5A; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    capture(-1, -1, 29);
    chk("rst_mid_cycle", kk, 30);
    chk("rst_mid_oen", {31'b0, oen[0]}, 1);
    chk("rst_mid_ti", {31'b0, ti[0]}, 1);
    chk("rst_mid_busy", {31'b0, bsy[0]}, 0);
    chk("rst_mid_oen_it0", {31'b0, oen[3]}, 1);
    rst = 1'b0;
    glitch = 0;
    repeat (16) begin
      step();
      if (ti[0] !== 1'b1 || oen[0] !== 1'b1 || bsy[0] !== 1'b0) glitch++;
    end
    chk("rst_mid_quiet", glitch, 0);
    chk("rst_mid_it0_oen", {31'b0, oen[3]}, 0);
    chk("rst_mid_it0_ti", {31'b0, ti[3]}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
